// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmitter shared definitions.
// FSM state encoding, default timing constants and frame length.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    XFER,
    WAIT_IDLE,
    DONE
  } state_t;

  localparam int INHIBIT_DEF = 5000;
  localparam int REQ_DEF     = 10;
  localparam int TIMEOUT_DEF = 750000;
  localparam int FRAME_EDGES = 11;
  localparam int TIMER_W     = 20;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake bundle for the PS/2 host transmitter.
// cmd_data/cmd_valid from the requester, cmd_ready back from the transmitter.
interface ps2_host_tx_if;

  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;

  modport master (
    output cmd_data,
    output cmd_valid,
    input  cmd_ready
  );

  modport slave (
    input  cmd_data,
    input  cmd_valid,
    output cmd_ready
  );

endinterface

// File: rtl/ps2_host_tx_sync_edge.sv
// Two-flop synchronizer plus falling-edge detector for one PS/2 line.
// Ports: clk, rst (async high), din (raw line), level (synced), fall (pulse).
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic s1;
  logic s2;
  logic prev;

  // Idle PS/2 lines are high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1   <= din;
      s2   <= s1;
      prev <= s2;
    end
  end

  assign level = s2;
  assign fall  = prev & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-edge frame.
// Ports: inclock, reset, cmd (handshake if), ps2_*_in raw lines,
// ps2_*_oe open-drain pulls, tx_active, done, ack_error, timeout_error.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_DEF,
  parameter int REQ_CYCLES     = REQ_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
  input  logic           inclock,
  input  logic           reset,
  ps2_host_tx_if.slave   cmd,
  input  logic           ps2_clk_in,
  input  logic           ps2_dat_in,
  output logic           ps2_clk_oe,
  output logic           ps2_dat_oe,
  output logic           tx_active,
  output logic           done,
  output logic           ack_error,
  output logic           timeout_error
);

  localparam logic [TIMER_W-1:0] INH_LAST = TIMER_W'(INHIBIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] REQ_LAST = TIMER_W'(REQ_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]         ACK_CNT  = 4'(FRAME_EDGES - 1);

  state_t               state;
  logic [7:0]           shreg;
  logic                 parity;
  logic [3:0]           bit_cnt;
  logic [TIMER_W-1:0]   timer;
  logic                 ack_bad;
  logic                 ready_q;

  logic clk_lvl;
  logic clk_fall;
  logic dat_lvl;
  logic dat_fall;

  ps2_sync_edge u_clk_sync (
    .clk   (inclock),
    .rst   (reset),
    .din   (ps2_clk_in),
    .level (clk_lvl),
    .fall  (clk_fall)
  );

  ps2_sync_edge u_dat_sync (
    .clk   (inclock),
    .rst   (reset),
    .din   (ps2_dat_in),
    .level (dat_lvl),
    .fall  (dat_fall)
  );

  assign cmd.cmd_ready = ready_q;

  always_ff @(posedge inclock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      shreg         <= '0;
      parity        <= 1'b0;
      bit_cnt       <= '0;
      timer         <= '0;
      ack_bad       <= 1'b0;
      ready_q       <= 1'b1;
      ps2_clk_oe    <= 1'b0;
      ps2_dat_oe    <= 1'b0;
      tx_active     <= 1'b0;
      done          <= 1'b0;
      ack_error     <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      done          <= 1'b0;
      ack_error     <= 1'b0;
      timeout_error <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            shreg      <= cmd.cmd_data;
            parity     <= odd_parity(cmd.cmd_data);
            bit_cnt    <= '0;
            timer      <= '0;
            ack_bad    <= 1'b0;
            ready_q    <= 1'b0;
            tx_active  <= 1'b1;
            ps2_clk_oe <= 1'b1;
            ps2_dat_oe <= 1'b0;
            state      <= INHIBIT;
          end
        end
        INHIBIT: begin
          if (timer == INH_LAST) begin
            timer      <= '0;
            ps2_dat_oe <= 1'b1;
            state      <= REQ;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        REQ: begin
          // Releasing the clock with data still low is the start bit.
          if (timer == REQ_LAST) begin
            timer      <= '0;
            ps2_clk_oe <= 1'b0;
            state      <= XFER;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        XFER: begin
          if (clk_fall) begin
            timer   <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            unique case (1'b1)
              (bit_cnt < 4'd8): begin
                ps2_dat_oe <= ~shreg[0];
                shreg      <= shreg >> 1;
              end
              (bit_cnt == 4'd8): ps2_dat_oe <= ~parity;
              (bit_cnt == 4'd9): ps2_dat_oe <= 1'b0;
              default: begin
                if (bit_cnt == ACK_CNT) begin
                  ack_bad <= dat_lvl;
                  state   <= WAIT_IDLE;
                end
              end
            endcase
          end else if (timer == TO_LAST) begin
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            done          <= 1'b1;
            timeout_error <= 1'b1;
            state         <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (clk_lvl && dat_lvl) begin
            done      <= 1'b1;
            ack_error <= ack_bad;
            state     <= DONE;
          end else if (clk_fall) begin
            timer <= '0;
          end else if (timer == TO_LAST) begin
            ps2_clk_oe    <= 1'b0;
            ps2_dat_oe    <= 1'b0;
            done          <= 1'b1;
            timeout_error <= 1'b1;
            state         <= DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DONE: begin
          ready_q   <= 1'b1;
          tx_active <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  logic unused_fall;
  assign unused_fall = dat_fall;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Scenario tasks run in sequence; one summary line at the end.
module tb_ps2_host_tx;

  localparam int INH  = 5000;
  localparam int REQN = 10;
  localparam int TO   = 2000;
  localparam int HALF = 10;

  logic inclock = 1'b0;
  logic reset   = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic ps2_clk_in;
  logic ps2_dat_in;
  logic ps2_clk_oe;
  logic ps2_dat_oe;
  logic tx_active;
  logic done;
  logic ack_error;
  logic timeout_error;

  int errors = 0;
  int checks = 0;

  ps2_host_tx_if cmd_if ();

  assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
  assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .REQ_CYCLES     (REQN),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .inclock       (inclock),
    .reset         (reset),
    .cmd           (cmd_if),
    .ps2_clk_in    (ps2_clk_in),
    .ps2_dat_in    (ps2_dat_in),
    .ps2_clk_oe    (ps2_clk_oe),
    .ps2_dat_oe    (ps2_dat_oe),
    .tx_active     (tx_active),
    .done          (done),
    .ack_error     (ack_error),
    .timeout_error (timeout_error)
  );

  always #10 inclock = ~inclock;

  task automatic test_reset();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_data  = 8'h00;
    reset = 1'b1;
    repeat (3) @(negedge inclock);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || ps2_clk_oe !== 1'b0 ||
        ps2_dat_oe !== 1'b0 || tx_active !== 1'b0 || done !== 1'b0 ||
        ack_error !== 1'b0 || timeout_error !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b clk_oe=%b dat_oe=%b act=%b done=%b ae=%b te=%b, required 1 0 0 0 0 0 0",
               cmd_if.cmd_ready, ps2_clk_oe, ps2_dat_oe, tx_active,
               done, ack_error, timeout_error);
    end
    reset = 1'b0;
    @(negedge inclock);
  endtask

  task automatic send(input logic [7:0] d);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready before send %h: got %b required 1", d, cmd_if.cmd_ready);
    end
    cmd_if.cmd_data  = d;
    cmd_if.cmd_valid = 1'b1;
    @(negedge inclock);
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (cmd_if.cmd_ready !== 1'b0 || tx_active !== 1'b1 ||
        ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL accept %h: rdy=%b act=%b clk_oe=%b dat_oe=%b, required 0 1 1 0",
               d, cmd_if.cmd_ready, tx_active, ps2_clk_oe, ps2_dat_oe);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic par,
                           input logic ack, input int edges,
                           input logic inject, input logic chain,
                           input logic [7:0] nxt);
    int   n;
    logic exp;
    n = 0;
    while (ps2_clk_oe !== 1'b0 && n < INH + REQN + 50) begin
      @(negedge inclock);
      n++;
    end
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b1) begin
      errors++;
      $display("FAIL start bit %h: clk_oe=%b dat_oe=%b, required 0 1",
               d, ps2_clk_oe, ps2_dat_oe);
    end
    for (int k = 1; k <= edges; k++) begin
      if (k == 11) dev_dat = ack;
      if (inject && k == 3) begin
        cmd_if.cmd_data  = 8'h55;
        cmd_if.cmd_valid = 1'b1;
      end
      if (inject && k == 5) cmd_if.cmd_valid = 1'b0;
      repeat (HALF) @(negedge inclock);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge inclock);
      if (k <= 8)       exp = ~d[k-1];
      else if (k == 9)  exp = ~par;
      else              exp = 1'b0;
      checks++;
      if (ps2_dat_oe !== exp) begin
        errors++;
        $display("FAIL %h edge%0d dat_oe: got %b required %b", d, k, ps2_dat_oe, exp);
      end
      dev_clk = 1'b1;
      if (k == 11) dev_dat = 1'b1;
    end
    if (edges == 11) begin
      n = 0;
      while (done !== 1'b1 && n < 100) begin
        @(negedge inclock);
        n++;
      end
      checks++;
      if (done !== 1'b1 || ack_error !== ack || timeout_error !== 1'b0) begin
        errors++;
        $display("FAIL done %h: done=%b ae=%b te=%b, required 1 %b 0",
                 d, done, ack_error, timeout_error, ack);
      end
      if (chain) begin
        cmd_if.cmd_data  = nxt;
        cmd_if.cmd_valid = 1'b1;
      end
      @(negedge inclock);
      checks++;
      if (done !== 1'b0 || cmd_if.cmd_ready !== 1'b1 || tx_active !== 1'b0 ||
          ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 || ack_error !== 1'b0) begin
        errors++;
        $display("FAIL after done %h: done=%b rdy=%b act=%b clk_oe=%b dat_oe=%b ae=%b, required 0 1 0 0 0 0",
                 d, done, cmd_if.cmd_ready, tx_active, ps2_clk_oe,
                 ps2_dat_oe, ack_error);
      end
      if (chain) begin
        @(negedge inclock);
        cmd_if.cmd_valid = 1'b0;
        checks++;
        if (cmd_if.cmd_ready !== 1'b0 || ps2_clk_oe !== 1'b1 || ps2_dat_oe !== 1'b0) begin
          errors++;
          $display("FAIL chained accept %h: rdy=%b clk_oe=%b dat_oe=%b, required 0 1 0",
                   nxt, cmd_if.cmd_ready, ps2_clk_oe, ps2_dat_oe);
        end
      end
    end
  endtask

  task automatic test_inhibit_timing();
    int n;
    int m;
    send(8'hF4);
    n = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b0 && n < INH + 10) begin
      n++;
      @(negedge inclock);
    end
    checks++;
    if (n != INH) begin
      errors++;
      $display("FAIL inhibit length: got %0d required %0d", n, INH);
    end
    m = 0;
    while (ps2_clk_oe === 1'b1 && ps2_dat_oe === 1'b1 && m < REQN + 10) begin
      m++;
      @(negedge inclock);
    end
    checks++;
    if (m != REQN) begin
      errors++;
      $display("FAIL request length: got %0d required %0d", m, REQN);
    end
    run_frame(8'hF4, 1'b0, 1'b0, 11, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_frame_ed();
    send(8'hED);
    run_frame(8'hED, 1'b1, 1'b0, 11, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_back_to_back();
    send(8'h01);
    run_frame(8'h01, 1'b0, 1'b0, 11, 1'b0, 1'b1, 8'hFF);
    run_frame(8'hFF, 1'b1, 1'b0, 11, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_ack_error();
    send(8'h55);
    run_frame(8'h55, 1'b1, 1'b1, 11, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_ignore_mid_cmd();
    send(8'hA5);
    run_frame(8'hA5, 1'b1, 1'b0, 11, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic test_timeout();
    int n;
    send(8'h12);
    run_frame(8'h12, 1'b1, 1'b0, 4, 1'b0, 1'b0, 8'h00);
    n = 0;
    while (done !== 1'b1 && n < TO + 100) begin
      @(negedge inclock);
      n++;
    end
    checks++;
    if (done !== 1'b1 || timeout_error !== 1'b1 || ack_error !== 1'b0 ||
        ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0 ||
        n < TO - HALF || n > TO - HALF + 4) begin
      errors++;
      $display("FAIL timeout: done=%b te=%b ae=%b clk_oe=%b dat_oe=%b wait=%0d, required 1 1 0 0 0 wait %0d..%0d",
               done, timeout_error, ack_error, ps2_clk_oe, ps2_dat_oe,
               n, TO - HALF, TO - HALF + 4);
    end
    @(negedge inclock);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || timeout_error !== 1'b0 || tx_active !== 1'b0) begin
      errors++;
      $display("FAIL after timeout: rdy=%b te=%b act=%b, required 1 0 0",
               cmd_if.cmd_ready, timeout_error, tx_active);
    end
  endtask

  task automatic test_reset_mid_xfer();
    send(8'h0F);
    run_frame(8'h0F, 1'b1, 1'b0, 6, 1'b0, 1'b0, 8'h00);
    checks++;
    if (ps2_dat_oe !== 1'b1 || tx_active !== 1'b1) begin
      errors++;
      $display("FAIL pre-reset edge6: dat_oe=%b act=%b, required 1 1", ps2_dat_oe, tx_active);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (ps2_clk_oe !== 1'b0 || ps2_dat_oe !== 1'b0) begin
      errors++;
      $display("FAIL async release: clk_oe=%b dat_oe=%b, required 0 0", ps2_clk_oe, ps2_dat_oe);
    end
    @(negedge inclock);
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || tx_active !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL in reset: rdy=%b act=%b done=%b, required 1 0 0",
               cmd_if.cmd_ready, tx_active, done);
    end
    reset = 1'b0;
    @(negedge inclock);
    send(8'hF4);
    run_frame(8'hF4, 1'b0, 1'b0, 11, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_inhibit_timing();
    test_frame_ed();
    test_back_to_back();
    test_ack_error();
    test_ignore_mid_cmd();
    test_timeout();
    test_reset_mid_xfer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
